// File: rtl/ysyx_25030081_mc_cu.sv
// Multi-cycle control unit: fetch/decode/exec/mem/wb sequencer for RV32I(E) with
// registered decode controls, a memory-wait watchdog and a sticky trap report.
module ysyx_25030081_mc_cu #(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    output logic        mem_wr,
    output logic [2:0]  mem_op,
    output logic [2:0]  ext_op,
    output logic        alu_a_src,
    output logic [1:0]  alu_b_src,
    output logic [3:0]  alu_op,
    output logic [3:0]  branch,
    output logic [1:0]  wb_sel,
    output logic        reg_wr,
    output logic        pc_we,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] EXT_I = 3'b000;
    localparam logic [2:0] EXT_S = 3'b001;
    localparam logic [2:0] EXT_B = 3'b010;
    localparam logic [2:0] EXT_U = 3'b011;
    localparam logic [2:0] EXT_J = 3'b100;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic [2:0] ext_op;
        logic       alu_a_src;
        logic [1:0] alu_b_src;
        logic [3:0] alu_op;
        logic [3:0] branch;
        logic [1:0] wb_sel;
        logic [2:0] mem_op;
        logic       is_load;
        logic       is_store;
        logic       rd_wr;
    } ctrl_t;

    state_t               state_q, state_d;
    logic [31:0]          ir_q;
    ctrl_t                ctrl_q, dec;
    logic                 dec_bad;
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 acc_q, acc_d;
    logic [1:0]           cause_d;
    logic                 stall;
    logic                 use_rd, use_rs1, use_rs2;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    // Instruction decode from the captured IR
    always_comb begin
        dec     = '0;
        dec_bad = 1'b1;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec_bad = 1'b0;
                dec.ext_op = EXT_U; dec.alu_b_src = 2'b01; dec.alu_op = 4'b1111;
                use_rd = 1'b1;
            end
            OP_AUIPC: begin
                dec_bad = 1'b0;
                dec.ext_op = EXT_U; dec.alu_a_src = 1'b1; dec.alu_b_src = 2'b01;
                use_rd = 1'b1;
            end
            OP_JAL: begin
                dec_bad = 1'b0;
                dec.ext_op = EXT_J; dec.alu_a_src = 1'b1; dec.alu_b_src = 2'b01;
                dec.branch = 4'b0001; dec.wb_sel = 2'b10;
                use_rd = 1'b1;
            end
            OP_JALR: begin
                dec_bad = (funct3 != 3'b000);
                dec.ext_op = EXT_I; dec.alu_b_src = 2'b01;
                dec.branch = 4'b0010; dec.wb_sel = 2'b10;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                dec_bad = (funct3[2:1] == 2'b01);
                dec.ext_op = EXT_B; dec.alu_b_src = 2'b00;
                dec.branch = {1'b1, funct3};
                dec.alu_op = funct3[2] ? {3'b001, funct3[1]} : 4'b1000;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                dec_bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
                dec.ext_op = EXT_I; dec.alu_b_src = 2'b01; dec.wb_sel = 2'b01;
                dec.mem_op = funct3; dec.is_load = 1'b1;
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OP_STORE: begin
                dec_bad = funct3[2] || (funct3 == 3'b011);
                dec.ext_op = EXT_S; dec.alu_b_src = 2'b01;
                dec.mem_op = funct3; dec.is_store = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            OP_IMM: begin
                case (funct3)
                    3'b001:  dec_bad = (funct7 != 7'd0);
                    3'b101:  dec_bad = ({funct7[6], funct7[4:0]} != 6'd0);
                    default: dec_bad = 1'b0;
                endcase
                dec.ext_op = EXT_I; dec.alu_b_src = 2'b01;
                dec.alu_op = {(funct3 == 3'b101) & funct7[5], funct3};
                use_rd = 1'b1; use_rs1 = 1'b1;
            end
            OP_REG: begin
                dec_bad = !((funct7 == 7'd0) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
                dec.alu_b_src = 2'b00;
                dec.alu_op = {funct7[5], funct3};
                use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: dec_bad = 1'b1;
        endcase
        // RV32E only has x0..x15
        if (RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
            dec_bad = 1'b1;
        dec.rd_wr = use_rd && (rd != 5'd0);
    end

    // Next-state, watchdog and trap-cause logic
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        acc_d   = acc_q;
        cause_d = trap_cause;
        stall   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (inst_valid && inst_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (dec_bad) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (ctrl_q.is_load || ctrl_q.is_store) begin
                    state_d = S_MEM;
                    wd_d    = '0;
                    acc_d   = 1'b0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // A response is only looked at once the request has been accepted
                if (!acc_q) begin
                    if (mem_req_ready) begin
                        if (ctrl_q.is_store) state_d = S_WB;
                        else                 acc_d   = 1'b1;
                    end else begin
                        stall = 1'b1;
                    end
                end else if (mem_rsp_valid) begin
                    state_d = S_WB;
                end else begin
                    stall = 1'b1;
                end
                if (stall) begin
                    if (wd_q == WD_LAST) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_TIMEOUT;
                        wd_d    = WD_MAX;
                    end else begin
                        wd_d = wd_q + TIMEOUT_W'(1);
                    end
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wd_q    <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            acc_q   <= acc_d;
        end
    end

    // IR, decode controls and outputs, all registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_q          <= '0;
            ctrl_q        <= '0;
            trap_cause    <= 2'b00;
            inst_ready    <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_wr        <= 1'b0;
            pc_we         <= 1'b0;
            reg_wr        <= 1'b0;
            trap          <= 1'b0;
        end else begin
            if ((state_q == S_FETCH) && inst_valid && inst_ready) ir_q <= inst;
            if ((state_q == S_DECODE) && !dec_bad) ctrl_q <= dec;
            trap_cause    <= cause_d;
            inst_ready    <= (state_d == S_FETCH);
            mem_req_valid <= (state_d == S_MEM) && !acc_d;
            mem_wr        <= (state_d == S_MEM) && !acc_d && ctrl_q.is_store;
            pc_we         <= (state_d == S_WB);
            reg_wr        <= (state_d == S_WB) && ctrl_q.rd_wr;
            trap          <= (state_d == S_TRAP);
        end
    end

    assign mem_op    = ctrl_q.mem_op;
    assign ext_op    = ctrl_q.ext_op;
    assign alu_a_src = ctrl_q.alu_a_src;
    assign alu_b_src = ctrl_q.alu_b_src;
    assign alu_op    = ctrl_q.alu_op;
    assign branch    = ctrl_q.branch;
    assign wb_sel    = ctrl_q.wb_sel;

endmodule

// File: tb/tb_ysyx_25030081_mc_cu.sv
// Bench for ysyx_25030081_mc_cu (RV32E=1, TIMEOUT_W=4): directed cases plus random
// instructions and memory timing, checked against an instruction-format reference model.
module tb_ysyx_25030081_mc_cu;

    localparam bit          RV32E     = 1'b1;
    localparam int unsigned TIMEOUT_W = 4;
    localparam int          WD_LIMIT  = (1 << TIMEOUT_W) - 1;
    localparam int          N_RANDOM  = 300;

    localparam logic [2:0] F_NONE = 3'd0;
    localparam logic [2:0] F_R    = 3'd1;
    localparam logic [2:0] F_I    = 3'd2;
    localparam logic [2:0] F_S    = 3'd3;
    localparam logic [2:0] F_B    = 3'd4;
    localparam logic [2:0] F_U    = 3'd5;
    localparam logic [2:0] F_J    = 3'd6;

    typedef struct packed {
        logic       legal;
        logic [2:0] fmt;
        logic [2:0] ext_op;
        logic       a_src;
        logic [1:0] b_src;
        logic [3:0] alu_op;
        logic [3:0] branch;
        logic [1:0] wb_sel;
        logic [2:0] mem_op;
        logic       is_load;
        logic       is_store;
        logic       reg_wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic        mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic        mem_wr;
    logic [2:0]  mem_op, ext_op;
    logic        alu_a_src;
    logic [1:0]  alu_b_src, wb_sel, trap_cause;
    logic [3:0]  alu_op, branch;
    logic        reg_wr, pc_we, trap;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] cur_inst = '0;

    always #5 clk = ~clk;

    ysyx_25030081_mc_cu #(.RV32E(RV32E), .TIMEOUT_W(TIMEOUT_W)) dut (
        .clk(clk), .rst(rst),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_wr(mem_wr), .mem_op(mem_op), .ext_op(ext_op),
        .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_op(alu_op),
        .branch(branch), .wb_sel(wb_sel), .reg_wr(reg_wr), .pc_we(pc_we),
        .trap(trap), .trap_cause(trap_cause)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (inst 0x%08h, t=%0t)", tag, got, exp, cur_inst, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference decode: classify by opcode, then derive most controls from the format
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t       e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [4:0] rd, rs1, rs2;
        bit         wr_rd, uses_rs1, uses_rs2;
        opc = w[6:0];  rd = w[11:7];   f3 = w[14:12];
        rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
        e = '0;
        case (opc)
            7'b0110111: begin e.legal = 1; e.fmt = F_U; e.alu_op = 4'hF; end
            7'b0010111: begin e.legal = 1; e.fmt = F_U; e.a_src = 1; end
            7'b1101111: begin e.legal = 1; e.fmt = F_J; e.a_src = 1; e.branch = 4'd1; e.wb_sel = 2'd2; end
            7'b1100111: begin e.legal = (f3 == 0); e.fmt = F_I; e.branch = 4'd2; e.wb_sel = 2'd2; end
            7'b1100011: begin
                e.legal = (f3 != 2) && (f3 != 3); e.fmt = F_B; e.branch = {1'b1, f3};
                if (f3 < 4)      e.alu_op = 4'b1000;
                else if (f3 < 6) e.alu_op = 4'b0010;
                else             e.alu_op = 4'b0011;
            end
            7'b0000011: begin
                e.legal = (f3 != 3) && (f3 != 6) && (f3 != 7); e.fmt = F_I;
                e.is_load = 1; e.wb_sel = 2'd1; e.mem_op = f3;
            end
            7'b0100011: begin e.legal = (f3 <= 2); e.fmt = F_S; e.is_store = 1; e.mem_op = f3; end
            7'b0010011: begin
                e.fmt = F_I;
                if (f3 == 1)      e.legal = (f7 == 0);
                else if (f3 == 5) e.legal = (f7 == 0) || (f7 == 7'h20);
                else              e.legal = 1;
                e.alu_op = {(f3 == 5) ? f7[5] : 1'b0, f3};
            end
            7'b0110011: begin
                e.fmt = F_R;
                e.legal = (f7 == 0) || ((f7 == 7'h20) && ((f3 == 0) || (f3 == 5)));
                e.alu_op = {f7[5], f3};
            end
            default: e.legal = 0;
        endcase
        case (e.fmt)
            F_S:     e.ext_op = 3'b001;
            F_B:     e.ext_op = 3'b010;
            F_U:     e.ext_op = 3'b011;
            F_J:     e.ext_op = 3'b100;
            default: e.ext_op = 3'b000;
        endcase
        e.b_src  = ((e.fmt == F_R) || (e.fmt == F_B)) ? 2'b00 : 2'b01;
        wr_rd    = e.fmt inside {F_R, F_I, F_U, F_J};
        uses_rs1 = e.fmt inside {F_R, F_I, F_S, F_B};
        uses_rs2 = e.fmt inside {F_R, F_S, F_B};
        if (RV32E && ((wr_rd && rd >= 16) || (uses_rs1 && rs1 >= 16) || (uses_rs2 && rs2 >= 16)))
            e.legal = 0;
        e.reg_wr = wr_rd && (rd != 0);
        return e;
    endfunction

    function automatic logic [4:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return 5'(16 + $urandom_range(0, 15));
        return 5'($urandom_range(0, 15));
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        case ($urandom_range(0, 9))
            0:       opc = 7'b0110111;
            1:       opc = 7'b0010111;
            2:       opc = 7'b1101111;
            3:       opc = 7'b1100111;
            4:       opc = 7'b1100011;
            5:       opc = 7'b0000011;
            6:       opc = 7'b0100011;
            7:       opc = 7'b0010011;
            8:       opc = 7'b0110011;
            default: opc = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        case ($urandom_range(0, 3))
            0, 1:    f7 = 7'h00;
            2:       f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        return {f7, rand_reg(), rand_reg(), f3, rand_reg(), opc};
    endfunction

    task automatic do_reset();
        rst = 1; inst_valid = 0; mem_req_ready = 0; mem_rsp_valid = 0;
        #1;
        check("rst_trap", {trap, trap_cause}, 0);
        check("rst_strobes", {mem_req_valid, mem_wr, pc_we, reg_wr}, 0);
        check("rst_ctrls", {ext_op, alu_a_src, alu_b_src, alu_op, branch, wb_sel, mem_op}, 0);
        tick();
        rst = 0;
        check("rst_exit_ready", inst_ready, 1);
        tick();
        check("idle_ready", inst_ready, 1);
    endtask

    task automatic expect_trap(input logic [1:0] cause);
        for (int i = 0; i < 3; i++) begin
            check("trap", trap, 1);
            check("trap_cause", trap_cause, cause);
            check("trap_quiet", {inst_ready, pc_we, reg_wr, mem_req_valid}, 0);
            inst_valid = 1;
            mem_req_ready = 1;
            mem_rsp_valid = 1;
            tick();
        end
        do_reset();
    endtask

    // One instruction from handshake to commit; d = ready delay, r = response delay
    task automatic run_inst(input logic [31:0] w, input int d, input int r);
        exp_t e;
        int   k, stalls;
        bit   accepted, prog, done;
        e = ref_decode(w);
        cur_inst = w;
        check("fetch_ready", inst_ready, 1);
        inst_valid = 1; inst = w;
        tick();
        inst_valid = 0; inst = $urandom;
        check("decode_busy", {inst_ready, pc_we, reg_wr, mem_req_valid}, 0);
        tick();
        if (!e.legal) begin
            expect_trap(2'b01);
            return;
        end
        check("no_trap", trap, 0);
        if (e.fmt != F_R) check("ext_op", ext_op, e.ext_op);
        check("alu_a_src", alu_a_src, e.a_src);
        check("alu_b_src", alu_b_src, e.b_src);
        check("alu_op", alu_op, e.alu_op);
        check("branch", branch, e.branch);
        check("wb_sel", wb_sel, e.wb_sel);
        if (e.is_load || e.is_store) check("mem_op", mem_op, e.mem_op);
        check("exec_busy", {pc_we, reg_wr, mem_req_valid}, 0);
        tick();
        if (e.is_load || e.is_store) begin
            k = 0; stalls = 0; accepted = 0; done = 0;
            while (!done) begin
                check("mem_req_valid", mem_req_valid, !accepted);
                if (!accepted) check("mem_wr", mem_wr, e.is_store);
                check("mem_no_commit", {pc_we, reg_wr, trap}, 0);
                prog = accepted ? (k == r) : (k == d);
                mem_req_ready = !accepted && prog;
                mem_rsp_valid = accepted ? prog : (prog && ($urandom_range(0, 1) == 1));
                tick();
                mem_req_ready = 0; mem_rsp_valid = 0;
                if (prog) begin
                    if (accepted || e.is_store) done = 1;
                    else begin accepted = 1; k = 0; end
                end else begin
                    stalls++; k++;
                    if (stalls == WD_LIMIT) begin
                        expect_trap(2'b10);
                        return;
                    end
                end
            end
            check("wb_req_low", mem_req_valid, 0);
        end
        check("wb_pc_we", pc_we, 1);
        check("wb_reg_wr", reg_wr, e.reg_wr);
        check("wb_alu_op_hold", alu_op, e.alu_op);
        tick();
        check("post_wb_idle", {pc_we, reg_wr}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish, got running, expected done");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1; inst_valid = 0; inst = '0; mem_req_ready = 0; mem_rsp_valid = 0;
        do_reset();

        run_inst(32'h003100B3, 0, 0);   // add x1,x2,x3
        run_inst(32'h00310033, 0, 0);   // add x0,x2,x3: no reg write
        run_inst(32'h0080A283, 2, 2);   // lw x5,8(x1)
        run_inst(32'h00512223, 3, 0);   // sw x5,4(x2)
        run_inst(32'h00512223, 0, 0);   // sw with immediate ready
        run_inst(32'h00000000, 0, 0);   // illegal all-zero word
        run_inst(32'h00000833, 0, 0);   // add x16,x0,x0 illegal under RV32E
        run_inst(32'h0080A283, 7, 7);   // 14 stall cycles, just under the watchdog
        run_inst(32'h0080A283, 1000, 0); // never accepted: watchdog trap

        // Reset while a load waits for acceptance
        cur_inst = 32'h0080A283;
        check("fetch_ready", inst_ready, 1);
        inst_valid = 1; inst = cur_inst;
        tick();
        inst_valid = 0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            check("wait_req_valid", mem_req_valid, 1);
            tick();
        end
        #3;
        rst = 1;
        #1;
        check("rst_async_req_drop", mem_req_valid, 0);
        check("rst_async_trap", trap, 0);
        tick();
        rst = 0;
        check("rst_mid_mem_ready", inst_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid_mem_no_commit", {pc_we, reg_wr, trap}, 0);
        end

        for (int n = 0; n < N_RANDOM; n++)
            run_inst(rand_inst(), $urandom_range(0, 6), $urandom_range(0, 6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
